// File: rtl/router_pkg.sv
// Shared router definitions: framer FSM states, default header bytes and sizes.
package router_pkg;

  localparam int UWIDTH_DEF  = 8;
  localparam int MAX_LEN_DEF = 16;

  localparam logic [7:0] TS1_DEF = 8'd0;
  localparam logic [7:0] TS2_DEF = 8'd1;
  localparam logic [7:0] TS3_DEF = 8'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    LEN,
    PAYLOAD,
    PARITY
  } framer_state_t;

  // Address width for an n-entry buffer; never zero so a 1-entry buffer still has a port.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/payload_buf.sv
// Payload store: MAX_LEN x UWIDTH register file, synchronous write, combinational read.
module payload_buf
  import router_pkg::*;
#(
  parameter int UWIDTH  = UWIDTH_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int AW      = addr_w(MAX_LEN)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [UWIDTH-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [UWIDTH-1:0] rdata_o
);

  logic [UWIDTH-1:0] mem_q [MAX_LEN];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/packet_framer.sv
// Buffers one command's payload, then emits header, length, payload and optional
// XOR trailer as one contiguous packet. Trailer enabled by PACKET_FRAMER_PARITY_EN.
module packet_framer
  import router_pkg::*;
#(
  parameter int                UWIDTH  = UWIDTH_DEF,
  parameter int                MAX_LEN = MAX_LEN_DEF,
  parameter logic [UWIDTH-1:0] TS1     = UWIDTH'(TS1_DEF),
  parameter logic [UWIDTH-1:0] TS2     = UWIDTH'(TS2_DEF),
  parameter logic [UWIDTH-1:0] TS3     = UWIDTH'(TS3_DEF)
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [1:0]        req_dest,
  input  logic [UWIDTH-1:0] req_len,
  output logic              req_ready,
  output logic              req_err,
  input  logic              data_valid,
  input  logic [UWIDTH-1:0] data_in,
  output logic              data_ready,
  input  logic              stop_packet_send,
  output logic              packet_valid_i,
  output logic [UWIDTH-1:0] packet_in,
  output logic [15:0]       pkt_count
);

  localparam int                AW        = addr_w(MAX_LEN);
  localparam logic [UWIDTH-1:0] ONE       = UWIDTH'(1);
  localparam logic [UWIDTH-1:0] MAX_LEN_U = UWIDTH'(MAX_LEN);

  framer_state_t     state_q;
  logic [1:0]        dest_q;
  logic [UWIDTH-1:0] len_q;
  logic [UWIDTH-1:0] cnt_q;
  logic              req_ready_q;
  logic              data_ready_q;
  logic              req_err_q;
  logic              pkt_valid_q;
  logic [UWIDTH-1:0] pkt_data_q;
  logic [15:0]       pkt_count_q;
`ifdef PACKET_FRAMER_PARITY_EN
  logic [UWIDTH-1:0] par_q;
`endif

  logic              cmd_legal_d;
  logic              byte_acc_d;
  logic [UWIDTH-1:0] rd_data_d;

  function automatic logic [UWIDTH-1:0] ts_sel(input logic [1:0] d);
    case (d)
      2'd1:    return TS1;
      2'd2:    return TS2;
      default: return TS3;
    endcase
  endfunction

  assign cmd_legal_d = (req_dest != 2'd0) && (req_len != '0) && (req_len <= MAX_LEN_U);
  assign byte_acc_d  = data_valid && data_ready_q;

  payload_buf #(
    .UWIDTH  (UWIDTH),
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk_i   (clk1),
    .we_i    (byte_acc_d),
    .waddr_i (cnt_q[AW-1:0]),
    .wdata_i (data_in),
    .raddr_i (cnt_q[AW-1:0]),
    .rdata_o (rd_data_d)
  );

  // State names the byte last put on the wire; a stall only drops valid and holds,
  // so the cycle after the stall clears presents the following byte.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      dest_q       <= 2'd0;
      len_q        <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      data_ready_q <= 1'b0;
      req_err_q    <= 1'b0;
      pkt_valid_q  <= 1'b0;
      pkt_data_q   <= '0;
      pkt_count_q  <= '0;
`ifdef PACKET_FRAMER_PARITY_EN
      par_q        <= '0;
`endif
    end else begin
      req_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (cmd_legal_d) begin
              dest_q       <= req_dest;
              len_q        <= req_len;
              cnt_q        <= '0;
              req_ready_q  <= 1'b0;
              data_ready_q <= 1'b1;
              state_q      <= LOAD;
`ifdef PACKET_FRAMER_PARITY_EN
              par_q        <= ts_sel(req_dest) ^ req_len;
`endif
            end else begin
              req_err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (data_valid) begin
`ifdef PACKET_FRAMER_PARITY_EN
            par_q <= par_q ^ data_in;
`endif
            if (cnt_q == len_q - ONE) begin
              cnt_q        <= '0;
              data_ready_q <= 1'b0;
              pkt_valid_q  <= 1'b1;
              pkt_data_q   <= ts_sel(dest_q);
              state_q      <= HEADER;
            end else begin
              cnt_q <= cnt_q + ONE;
            end
          end
        end
        default: begin
          if (stop_packet_send) begin
            pkt_valid_q <= 1'b0;
          end else begin
            pkt_valid_q <= 1'b1;
            case (state_q)
              HEADER: begin
                pkt_data_q <= len_q;
                state_q    <= LEN;
              end
              LEN: begin
                pkt_data_q <= rd_data_d;
                cnt_q      <= cnt_q + ONE;
                state_q    <= PAYLOAD;
              end
              PAYLOAD: begin
                if (cnt_q == len_q) begin
`ifdef PACKET_FRAMER_PARITY_EN
                  pkt_data_q <= par_q;
                  state_q    <= PARITY;
`else
                  pkt_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  pkt_count_q <= pkt_count_q + 16'd1;
                  state_q     <= IDLE;
`endif
                end else begin
                  pkt_data_q <= rd_data_d;
                  cnt_q      <= cnt_q + ONE;
                end
              end
              default: begin
                pkt_valid_q <= 1'b0;
                req_ready_q <= 1'b1;
                pkt_count_q <= pkt_count_q + 16'd1;
                state_q     <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign data_ready     = data_ready_q;
  assign req_err        = req_err_q;
  assign packet_valid_i = pkt_valid_q;
  assign packet_in      = pkt_data_q;
  assign pkt_count      = pkt_count_q;

endmodule

// File: tb/tb_packet_framer.sv
// Scoreboard bench for packet_framer: expected wire bytes are queued per command
// and popped as the framer emits them. Trailer expected when PACKET_FRAMER_PARITY_EN is set.
module tb_packet_framer;

  logic        clk1 = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_dest = 2'd0;
  logic [7:0]  req_len = 8'd0;
  logic        req_ready;
  logic        req_err;
  logic        data_valid = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic        data_ready;
  logic        stop_packet_send = 1'b0;
  logic        packet_valid_i;
  logic [7:0]  packet_in;
  logic [15:0] pkt_count;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [7:0]  exp_q[$];
  logic [7:0]  pl[16];

  always #5 clk1 = ~clk1;

  packet_framer dut (
    .clk1             (clk1),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_dest         (req_dest),
    .req_len          (req_len),
    .req_ready        (req_ready),
    .req_err          (req_err),
    .data_valid       (data_valid),
    .data_in          (data_in),
    .data_ready       (data_ready),
    .stop_packet_send (stop_packet_send),
    .packet_valid_i   (packet_valid_i),
    .packet_in        (packet_in),
    .pkt_count        (pkt_count)
  );

  function automatic logic [7:0] hdr_of(input logic [1:0] d);
    logic [7:0] tbl [4];
    tbl[0] = 8'hxx; tbl[1] = 8'h00; tbl[2] = 8'h01; tbl[3] = 8'h02;
    return tbl[d];
  endfunction

  function automatic void push_pkt(input logic [1:0] d, input int l);
    logic [7:0] par;
    par = hdr_of(d) ^ 8'(l);
    exp_q.push_back(hdr_of(d));
    exp_q.push_back(8'(l));
    for (int i = 0; i < l; i++) begin
      exp_q.push_back(pl[i]);
      par = par ^ pl[i];
    end
`ifdef PACKET_FRAMER_PARITY_EN
    exp_q.push_back(par);
`endif
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_cmd(input logic [1:0] d, input logic [7:0] l);
    int w;
    w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clk1);
      w++;
    end
    n_checks++;
    if (w >= 200) begin
      n_fail++;
      $display("FAIL cmd_wait: req_ready=%0b after %0d cycles, required 1", req_ready, w);
    end
    req_valid = 1'b1;
    req_dest  = d;
    req_len   = l;
    @(negedge clk1);
    req_valid = 1'b0;
  endtask

  // Returns at the negedge following the edge that accepted the last byte.
  task automatic send_data(input int n, input bit gap);
    int w;
    for (int i = 0; i < n; i++) begin
      data_valid = 1'b1;
      data_in    = pl[i];
      w = 0;
      while (!data_ready && w < 200) begin
        @(negedge clk1);
        w++;
      end
      if (w >= 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL data_wait: data_ready=%0b after %0d cycles, required 1", data_ready, w);
      end
      @(negedge clk1);
      if (gap && i < n - 1) begin
        data_valid = 1'b0;
        @(negedge clk1);
      end
    end
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk1);
    n_checks++;
    if ({packet_valid_i, packet_in, req_ready, data_ready, req_err} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b data=%02h rr=%0b dr=%0b err=%0b, required 0 00 1 0 0",
               packet_valid_i, packet_in, req_ready, data_ready, req_err);
    end
    n_checks++;
    if (pkt_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_count: pkt_count=%0d, required 0", pkt_count);
    end
    rst = 1'b1;
    @(negedge clk1);
  endtask

  task automatic test_basic();
    logic [7:0] e;
    int bubbles;
    bit started;
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
    push_pkt(2'd2, 3);
    send_cmd(2'd2, 8'd3);
    n_checks++;
    if (data_ready !== 1'b1 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_load_entry: dr=%0b rr=%0b, required 1 0", data_ready, req_ready);
    end
    send_data(3, 1'b0);
    bubbles = 0;
    started = 1'b0;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      if (c > 0) @(negedge clk1);
      if (packet_valid_i) begin
        started = 1'b1;
        e = exp_q.pop_front();
        n_checks++;
        if (packet_in !== e) begin
          n_fail++;
          $display("FAIL basic_byte: got %02h, required %02h", packet_in, e);
        end
      end else if (started) begin
        bubbles++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || bubbles != 0) begin
      n_fail++;
      $display("FAIL basic_contig: left=%0d bubbles=%0d, required 0 0", exp_q.size(), bubbles);
    end
    exp_q.delete();
    exp_cnt++;
    @(negedge clk1);
    n_checks++;
    if (packet_valid_i !== 1'b0 || req_ready !== 1'b1 || pkt_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL basic_end: valid=%0b rr=%0b cnt=%0d, required 0 1 %0d",
               packet_valid_i, req_ready, pkt_count, exp_cnt);
    end
  endtask

  task automatic test_stall();
    logic [7:0] e;
    int bubbles, idx, stall_at;
    bit started;
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
    push_pkt(2'd2, 3);
    send_cmd(2'd2, 8'd3);
    send_data(3, 1'b0);
    bubbles = 0;
    idx = 0;
    stall_at = -10;
    started = 1'b0;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      if (c > 0) @(negedge clk1);
      if (packet_valid_i) begin
        started = 1'b1;
        e = exp_q.pop_front();
        n_checks++;
        if (packet_in !== e) begin
          n_fail++;
          $display("FAIL stall_byte: idx %0d got %02h, required %02h", idx, packet_in, e);
        end
        if (idx == 2) begin
          stop_packet_send = 1'b1;
          stall_at = c;
        end
        idx++;
      end else if (started) begin
        bubbles++;
      end
      if (c == stall_at + 2) stop_packet_send = 1'b0;
    end
    stop_packet_send = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || bubbles != 2) begin
      n_fail++;
      $display("FAIL stall_bubbles: left=%0d bubbles=%0d, required 0 2", exp_q.size(), bubbles);
    end
    exp_q.delete();
    exp_cnt++;
    @(negedge clk1);
    n_checks++;
    if (packet_valid_i !== 1'b0 || pkt_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL stall_end: valid=%0b cnt=%0d, required 0 %0d (no duplicate bytes)",
               packet_valid_i, pkt_count, exp_cnt);
    end
  endtask

  task automatic test_errors();
    logic [1:0] d [3];
    logic [7:0] l [3];
    d[0] = 2'd1; l[0] = 8'd0;
    d[1] = 2'd1; l[1] = 8'd17;
    d[2] = 2'd0; l[2] = 8'd3;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_dest  = d[k];
      req_len   = l[k];
      @(negedge clk1);
      req_valid = 1'b0;
      n_checks++;
      if (req_err !== 1'b1 || req_ready !== 1'b1 || data_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL err_pulse[%0d]: err=%0b rr=%0b dr=%0b, required 1 1 0", k, req_err, req_ready, data_ready);
      end
      @(negedge clk1);
      n_checks++;
      if (req_err !== 1'b0 || req_ready !== 1'b1 || packet_valid_i !== 1'b0) begin
        n_fail++;
        $display("FAIL err_after[%0d]: err=%0b rr=%0b valid=%0b, required 0 1 0",
                 k, req_err, req_ready, packet_valid_i);
      end
    end
  endtask

  task automatic test_max_len_gaps();
    logic [7:0] e;
    int bubbles, nbytes, want;
    bit started;
    for (int i = 0; i < 16; i++) pl[i] = 8'($urandom_range(0, 255));
    push_pkt(2'd3, 16);
    want = exp_q.size();
    send_cmd(2'd3, 8'd16);
    send_data(16, 1'b1);
    n_checks++;
    if (packet_valid_i !== 1'b1 || packet_in !== 8'h02) begin
      n_fail++;
      $display("FAIL maxlen_hdr_timing: valid=%0b data=%02h, required 1 02", packet_valid_i, packet_in);
    end
    bubbles = 0;
    nbytes = 0;
    started = 1'b0;
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      if (c > 0) @(negedge clk1);
      if (packet_valid_i) begin
        started = 1'b1;
        nbytes++;
        e = exp_q.pop_front();
        n_checks++;
        if (packet_in !== e) begin
          n_fail++;
          $display("FAIL maxlen_byte: got %02h, required %02h", packet_in, e);
        end
      end else if (started) begin
        bubbles++;
      end
    end
    n_checks++;
    if (nbytes != want || bubbles != 0) begin
      n_fail++;
      $display("FAIL maxlen_contig: bytes=%0d bubbles=%0d, required %0d 0", nbytes, bubbles, want);
    end
    exp_q.delete();
    exp_cnt++;
    @(negedge clk1);
    n_checks++;
    if (packet_valid_i !== 1'b0 || req_ready !== 1'b1 || pkt_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL maxlen_end: valid=%0b rr=%0b cnt=%0d, required 0 1 %0d",
               packet_valid_i, req_ready, pkt_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] e;
    int idx;
    bit hit;
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
    push_pkt(2'd3, 4);
    send_cmd(2'd3, 8'd4);
    send_data(4, 1'b0);
    idx = 0;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (c > 0) @(negedge clk1);
      if (packet_valid_i) begin
        e = exp_q.pop_front();
        n_checks++;
        if (packet_in !== e) begin
          n_fail++;
          $display("FAIL rstmid_byte: got %02h, required %02h", packet_in, e);
        end
        if (idx == 3) hit = 1'b1;
        idx++;
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rstmid_reach: bytes seen=%0d, required 4", idx);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (packet_valid_i !== 1'b0 || req_ready !== 1'b1 || pkt_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: valid=%0b rr=%0b cnt=%0d, required 0 1 0",
               packet_valid_i, req_ready, pkt_count);
    end
    exp_q.delete();
    exp_cnt = 16'd0;
    @(negedge clk1);
    rst = 1'b1;
    repeat (3) @(negedge clk1);
    n_checks++;
    if (packet_valid_i !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: valid=%0b, required 0", packet_valid_i);
    end
  endtask

  task automatic test_short_packet();
    logic [7:0] e;
    int nbytes;
    pl[0] = 8'h55;
    push_pkt(2'd1, 1);
    send_cmd(2'd1, 8'd1);
    send_data(1, 1'b0);
    nbytes = 0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (c > 0) @(negedge clk1);
      if (packet_valid_i) begin
        nbytes++;
        e = exp_q.pop_front();
        n_checks++;
        if (packet_in !== e) begin
          n_fail++;
          $display("FAIL short_byte: idx %0d got %02h, required %02h", nbytes - 1, packet_in, e);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL short_timeout: %0d bytes outstanding, required 0", exp_q.size());
    end
    exp_q.delete();
    exp_cnt++;
    @(negedge clk1);
    n_checks++;
    if (packet_valid_i !== 1'b0 || pkt_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL short_end: valid=%0b cnt=%0d, required 0 %0d", packet_valid_i, pkt_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_errors();
    test_max_len_gaps();
    test_reset_mid_packet();
    test_basic();
    test_short_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
